ejeta_temporizador: RTL

- Parametrised successor to the single-channel eject timer. Runs a free-running time base and arbitrates immediate and delayed eject requests through an explicit FSM.
- Drives a fixed-width eject pulse, timestamps each eject and keeps a saturating eject count.
- Sits between the process counter (saida_contador) and the selection/menu logic (seleciona, seleciona_opcoes) in the appliance control path.

---
 rtl/ejeta_temporizador.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ejeta_temporizador.sv
// Eject timer: free-running time base plus an IDLE/DELAY/EJECT arbiter that issues a fixed-width eject pulse.
// Optional idle watchdog eject is enabled with `define EJETA_WATCHDOG_EN.
//
// state | meaning
// IDLE  | waiting for a request
// DELAY | counting down from a counter falling edge to a delayed eject
// EJECT | eject pulse active for HOLD_CYCLES cycles
module ejeta_temporizador #(
  parameter int TIME_W         = 9,
  parameter int DELAY_CYCLES   = 5,
  parameter int HOLD_CYCLES    = 4,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seleciona,
  input  logic              seleciona_opcoes,
  input  logic              saida_contador,
  output logic [TIME_W-1:0] tempo,
  output logic              ejeta,
  output logic [1:0]        estado,
  output logic [TIME_W-1:0] marca_tempo,
  output logic [CNT_W-1:0]  contagem_ejecoes,
  output logic              timeout
);

  localparam int DW = $clog2(DELAY_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    EJECT = 2'd2
  } state_t;

  state_t        state, state_d;
  logic          sc_q;
  logic [DW-1:0] dcnt, dcnt_d;
  logic [HW-1:0] hcnt, hcnt_d;
  logic          entry;
  logic          timeout_d;
  logic          rise, fall, imm, cancel, dly;

`ifdef EJETA_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wcnt, wcnt_d;
`endif

  assign rise   = saida_contador & ~sc_q;
  assign fall   = ~saida_contador & sc_q;
  assign imm    = rise | (seleciona & seleciona_opcoes);
  assign cancel = seleciona & ~seleciona_opcoes;
  assign dly    = fall;
  assign estado = state;

  always_comb begin
    state_d   = state;
    dcnt_d    = dcnt;
    hcnt_d    = hcnt;
    entry     = 1'b0;
    timeout_d = 1'b0;
`ifdef EJETA_WATCHDOG_EN
    wcnt_d    = '0;
`endif
    case (state)
      IDLE: begin
        if (imm) begin
          entry = 1'b1;
        end else if (dly) begin
          state_d = DELAY;
          dcnt_d  = DW'(DELAY_CYCLES);
`ifdef EJETA_WATCHDOG_EN
        end else if (cancel) begin
          wcnt_d = '0;
        end else if (wcnt == WW'(TIMEOUT_CYCLES - 1)) begin
          entry     = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt + 1'b1;
`endif
        end
      end
      DELAY: begin
        if (imm) begin
          entry = 1'b1;
        end else if (cancel) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dly) begin
          dcnt_d = DW'(DELAY_CYCLES);
        end else if (dcnt == DW'(1)) begin
          entry = 1'b1;
        end else begin
          dcnt_d = dcnt - 1'b1;
        end
      end
      EJECT: begin
        // only imm matters here; it restarts the pulse as a fresh entry
        if (imm) begin
          entry = 1'b1;
        end else if (hcnt == HW'(1)) begin
          state_d = IDLE;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (entry) begin
      state_d = EJECT;
      hcnt_d  = HW'(HOLD_CYCLES);
      dcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      dcnt             <= '0;
      hcnt             <= '0;
      sc_q             <= 1'b0;
      tempo            <= '0;
      ejeta            <= 1'b0;
      marca_tempo      <= '0;
      contagem_ejecoes <= '0;
      timeout          <= 1'b0;
    end else begin
      state   <= state_d;
      dcnt    <= dcnt_d;
      hcnt    <= hcnt_d;
      sc_q    <= saida_contador;
      tempo   <= tempo + 1'b1;
      ejeta   <= (state_d == EJECT);
      timeout <= timeout_d;
      if (entry) begin
        marca_tempo <= tempo;
        if (~&contagem_ejecoes) contagem_ejecoes <= contagem_ejecoes + 1'b1;
      end
    end
  end

`ifdef EJETA_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wcnt <= '0;
    else     wcnt <= wcnt_d;
  end
`endif

endmodule
